// File: rtl/tod_pkg.sv
// rtl/tod_pkg.sv - field select codes, field limits and 12h display helper for tod_counter
package tod_pkg;

  typedef enum logic [1:0] {
    SEL_SEC  = 2'd0,
    SEL_MIN  = 2'd1,
    SEL_HOUR = 2'd2,
    SEL_RSVD = 2'd3
  } tod_sel_e;

  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HOUR_W   = 5;
  localparam int MAX_SEC  = 59;
  localparam int MAX_MIN  = 59;
  localparam int MAX_HOUR = 23;

  // Midnight shows as 12, afternoon hours fold down by 12.
  function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] hour);
    if (hour == '0) begin
      return HOUR_W'(12);
    end else if (hour > HOUR_W'(12)) begin
      return hour - HOUR_W'(12);
    end else begin
      return hour;
    end
  endfunction

endpackage

// File: rtl/tod_prescaler.sv
// rtl/tod_prescaler.sv - divides enabled clock cycles down to a one-per-second tick.
// tick is combinational; clr restarts the count so a field write begins a fresh second.
module tod_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clr,
  output logic tick
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  assign tick = enable && (pre_q == PRE_MAX);

  always_comb begin
    pre_d = pre_q;
    if (clr || tick) begin
      pre_d = '0;
    end else if (enable) begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/tod_counter.sv
// rtl/tod_counter.sv - HH:MM:SS time-of-day counter with range-checked writes and 12h view.
// Defining TOD_ALARM_EN adds an armable hour:minute alarm with its own checked write port.
module tod_counter
  import tod_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [1:0]        wr_sel,
  input  logic [5:0]        wr_data,
  input  logic              mode12,
`ifdef TOD_ALARM_EN
  input  logic              alarm_wr,
  input  logic [10:0]       alarm_hm,
  input  logic              alarm_arm,
  output logic              alarm_hit,
`endif
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic [HOUR_W-1:0] disp_hour,
  output logic              pm,
  output logic              sec_tick,
  output logic              day_wrap,
  output logic              wr_err
);

  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              sec_tick_q, sec_tick_d;
  logic              day_wrap_q, day_wrap_d;
  logic              wr_err_q, wr_err_d;
  logic              tick;
  logic              wr_ok;
  logic              wr_fire;
  logic              adv;
  logic              alarm_bad;

  always_comb begin
    wr_ok = 1'b0;
    case (tod_sel_e'(wr_sel))
      SEL_SEC:  wr_ok = (wr_data <= 6'(MAX_SEC));
      SEL_MIN:  wr_ok = (wr_data <= 6'(MAX_MIN));
      SEL_HOUR: wr_ok = (wr_data <= 6'(MAX_HOUR));
      default:  wr_ok = 1'b0;
    endcase
  end

  assign wr_fire = wr_en && wr_ok;
  // A valid write swallows a coincident tick; the prescaler restarts from zero.
  assign adv     = tick && !wr_fire;

  tod_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .clr   (wr_fire),
    .tick  (tick)
  );

  always_comb begin
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    if (wr_fire) begin
      case (tod_sel_e'(wr_sel))
        SEL_SEC:  sec_d  = wr_data;
        SEL_MIN:  min_d  = wr_data;
        SEL_HOUR: hour_d = wr_data[HOUR_W-1:0];
        default:  sec_d  = sec_q;
      endcase
    end else if (adv) begin
      sec_tick_d = 1'b1;
      if (sec_q == SEC_W'(MAX_SEC)) begin
        sec_d = '0;
        if (min_q == MIN_W'(MAX_MIN)) begin
          min_d = '0;
          if (hour_q == HOUR_W'(MAX_HOUR)) begin
            hour_d     = '0;
            day_wrap_d = 1'b1;
          end else begin
            hour_d = hour_q + 1'b1;
          end
        end else begin
          min_d = min_q + 1'b1;
        end
      end else begin
        sec_d = sec_q + 1'b1;
      end
    end
  end

  assign wr_err_d = (wr_en && !wr_ok) || alarm_bad;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
      wr_err_q   <= wr_err_d;
    end
  end

`ifdef TOD_ALARM_EN
  logic [HOUR_W-1:0] alarm_hour_q;
  logic [MIN_W-1:0]  alarm_min_q;
  logic              alarm_hit_q;
  logic              alarm_ok;
  logic              alarm_hit_d;

  assign alarm_ok    = (alarm_hm[10:6] <= HOUR_W'(MAX_HOUR)) && (alarm_hm[5:0] <= MIN_W'(MAX_MIN));
  assign alarm_bad   = alarm_wr && !alarm_ok;
  // Only a counted second can fire the alarm, never a write landing on the alarm time.
  assign alarm_hit_d = adv && alarm_arm && (sec_d == '0) &&
                       (hour_d == alarm_hour_q) && (min_d == alarm_min_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alarm_hour_q <= '0;
      alarm_min_q  <= '0;
      alarm_hit_q  <= 1'b0;
    end else begin
      if (alarm_wr && alarm_ok) begin
        alarm_hour_q <= alarm_hm[10:6];
        alarm_min_q  <= alarm_hm[5:0];
      end
      alarm_hit_q <= alarm_hit_d;
    end
  end

  assign alarm_hit = alarm_hit_q;
`else
  assign alarm_bad = 1'b0;
`endif

  assign sec       = sec_q;
  assign min       = min_q;
  assign hour      = hour_q;
  assign disp_hour = mode12 ? to_12h(hour_q) : hour_q;
  assign pm        = mode12 && (hour_q >= HOUR_W'(12));
  assign sec_tick  = sec_tick_q;
  assign day_wrap  = day_wrap_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_tod_counter.sv
// tb/tb_tod_counter.sv - self-checking bench for tod_counter (TICK_DIV=4), seconds-of-day model.
module tb_tod_counter;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_sel = '0;
  logic [5:0] wr_data = '0;
  logic       mode12 = 1'b0;
  logic [5:0] sec, min;
  logic [4:0] hour, disp_hour;
  logic       pm, sec_tick, day_wrap, wr_err;
`ifdef TOD_ALARM_EN
  logic        alarm_wr = 1'b0;
  logic        alarm_arm = 1'b0;
  logic [10:0] alarm_hm = '0;
  logic        alarm_hit;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: time as seconds since midnight, enabled cycles since the last second.
  int t, e, al_h, al_m;
  int mh, mm, ms;
  bit mtk, mok;
  bit x_tick, x_wrap, x_err, x_hit;

  tod_counter #(.TICK_DIV(TD)) dut (
    .clock    (clk),
    .reset    (rst_n),
    .enable   (enable),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .mode12   (mode12),
`ifdef TOD_ALARM_EN
    .alarm_wr (alarm_wr),
    .alarm_hm (alarm_hm),
    .alarm_arm(alarm_arm),
    .alarm_hit(alarm_hit),
`endif
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .disp_hour(disp_hour),
    .pm       (pm),
    .sec_tick (sec_tick),
    .day_wrap (day_wrap),
    .wr_err   (wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int now_s();
    return int'(hour) * 3600 + int'(min) * 60 + int'(sec);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0; e = 0; al_h = 0; al_m = 0;
      x_tick = 0; x_wrap = 0; x_err = 0; x_hit = 0;
    end else begin
      x_tick = 0; x_wrap = 0; x_err = 0; x_hit = 0;
      mtk = 0;
      if (enable) begin
        e++;
        if (e == TD) begin
          mtk = 1;
          e = 0;
        end
      end
      mok = wr_en && (wr_sel != 2'd3) && (int'(wr_data) <= ((wr_sel == 2'd2) ? 23 : 59));
      if (wr_en && !mok) x_err = 1;
      if (mok) begin
        mh = t / 3600; mm = (t / 60) % 60; ms = t % 60;
        if (wr_sel == 2'd0) ms = int'(wr_data);
        else if (wr_sel == 2'd1) mm = int'(wr_data);
        else mh = int'(wr_data);
        t = mh * 3600 + mm * 60 + ms;
        e = 0;
      end else if (mtk) begin
        t = (t + 1) % 86400;
        x_tick = 1;
        x_wrap = (t == 0);
`ifdef TOD_ALARM_EN
        x_hit = alarm_arm && (t % 60 == 0) && (t / 60 == al_h * 60 + al_m);
`endif
      end
`ifdef TOD_ALARM_EN
      if (alarm_wr) begin
        if (int'(alarm_hm[10:6]) <= 23 && int'(alarm_hm[5:0]) <= 59) begin
          al_h = int'(alarm_hm[10:6]);
          al_m = int'(alarm_hm[5:0]);
        end else begin
          x_err = 1;
        end
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("time", now_s(), t);
      chk("sec_tick", int'(sec_tick), int'(x_tick));
      chk("day_wrap", int'(day_wrap), int'(x_wrap));
      chk("wr_err", int'(wr_err), int'(x_err));
      chk("disp_hour", int'(disp_hour),
          mode12 ? (((t / 3600) % 12 == 0) ? 12 : (t / 3600) % 12) : t / 3600);
      chk("pm", int'(pm), int'(mode12 && (t / 3600 >= 12)));
`ifdef TOD_ALARM_EN
      chk("alarm_hit", int'(alarm_hit), int'(x_hit));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input int d);
    wr_en = 1'b1;
    wr_sel = 2'(s);
    wr_data = 6'(d);
    cyc();
    wr_en = 1'b0;
  endtask

  initial begin
    int nt, nw, n;
    mode12 = 1'b1;
    #3;
    chk("rst_time", now_s(), 0);
    chk("rst_disp12", int'(disp_hour), 12);
    chk("rst_pm", int'(pm), 0);
    chk("rst_pulses", int'(sec_tick) + int'(day_wrap) + int'(wr_err), 0);
    rst_n = 1'b1;
    mode12 = 1'b0;
    cyc();

    // Async reset while running at 05:06:0x with a second pulse in flight.
    wr(2, 5); wr(1, 6); wr(0, 7);
    enable = 1'b1;
    repeat (4) cyc();
    chk("t1_time", now_s(), 5 * 3600 + 6 * 60 + 8);
    chk("t1_tick", int'(sec_tick), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_time", now_s(), 0);
    chk("t1_async_tick", int'(sec_tick), 0);
    enable = 1'b0;
    cyc();
    rst_n = 1'b1;

    // Day wrap.
    wr(2, 23); wr(1, 59); wr(0, 58);
    enable = 1'b1;
    nt = 0; nw = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      nt += int'(sec_tick);
      nw += int'(day_wrap);
      if (i == 3) chk("t2_235959", now_s(), 86399);
    end
    enable = 1'b0;
    chk("t2_ticks", nt, 2);
    chk("t2_wraps", nw, 1);
    chk("t2_midnight", now_s(), 0);

    // Rejected and boundary writes.
    wr(1, 17);
    wr(0, 60);
    chk("t3_err_sec60", int'(wr_err), 1);
    wr(3, 5);
    chk("t3_err_sel3", int'(wr_err), 1);
    wr(2, 24);
    chk("t3_err_hour24", int'(wr_err), 1);
    chk("t3_unchanged", now_s(), 17 * 60);
    wr(2, 23);
    chk("t3_hour23_ok", int'(wr_err), 0);
    wr(0, 59);
    chk("t3_time", now_s(), 23 * 3600 + 17 * 60 + 59);

    // Hold while disabled, then the 12h view.
    repeat (20) cyc();
    chk("t4_hold", now_s(), 23 * 3600 + 17 * 60 + 59);
    mode12 = 1'b1;
    wr(2, 0);
    chk("t4_disp_0", int'(disp_hour), 12);
    chk("t4_pm_0", int'(pm), 0);
    wr(2, 13);
    chk("t4_disp_13", int'(disp_hour), 1);
    chk("t4_pm_13", int'(pm), 1);
    wr(2, 12);
    chk("t4_disp_12", int'(disp_hour), 12);
    chk("t4_pm_12", int'(pm), 1);
    mode12 = 1'b0;

    // Valid write on the tick cycle beats the carry.
    wr(1, 59); wr(0, 59);
    enable = 1'b1;
    repeat (3) cyc();
    wr(0, 30);
    chk("t5_written", now_s(), 12 * 3600 + 59 * 60 + 30);
    chk("t5_no_tick", int'(sec_tick), 0);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!sec_tick && n < 10);
    chk("t5_gap", n, 4);
    chk("t5_next", now_s(), 12 * 3600 + 59 * 60 + 31);
    enable = 1'b0;

`ifdef TOD_ALARM_EN
    alarm_hm = {5'd7, 6'd30};
    alarm_wr = 1'b1;
    alarm_arm = 1'b1;
    cyc();
    alarm_wr = 1'b0;
    chk("t6_alarm_wr_ok", int'(wr_err), 0);
    wr(2, 7); wr(1, 29); wr(0, 59);
    enable = 1'b1;
    n = 0;
    repeat (8) begin cyc(); n += int'(alarm_hit); end
    enable = 1'b0;
    chk("t6_armed_hits", n, 1);
    chk("t6_time", now_s(), 7 * 3600 + 30 * 60 + 1);
    alarm_arm = 1'b0;
    wr(1, 29); wr(0, 59);
    enable = 1'b1;
    n = 0;
    repeat (8) begin cyc(); n += int'(alarm_hit); end
    enable = 1'b0;
    chk("t6_disarmed_hits", n, 0);
    alarm_arm = 1'b1;
    n = 0;
    wr(1, 30); n += int'(alarm_hit);
    wr(0, 0);  n += int'(alarm_hit);
    cyc();     n += int'(alarm_hit);
    chk("t6_direct_hits", n, 0);
    alarm_hm = {5'd24, 6'd0};
    alarm_wr = 1'b1;
    cyc();
    alarm_wr = 1'b0;
    chk("t6_alarm_bad", int'(wr_err), 1);
`endif

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
